writeback_commit_n: RTL
=======================

# writeback_commit_n

Parametrised N-lane writeback/commit stage sitting between the memory stage and the register file / CSR unit. Each cycle it accepts one bundle of up to LANES in-order instructions and commits them to the register file in program order. It also resolves the oldest exception, interrupt, ecall or mret in the bundle and squashes younger lanes. It then drives a held redirect to the front end until that redirect is acknowledged.

## Interface
Parameters:
- LANES, 2, commit width (1..4); lane 0 is oldest.
- XLEN, 64, data/PC width.
- CODE_W, 4, trap cause code width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  bundle present.
- in_ready  out  1  stage can accept a bundle.
- in_lane_valid  in  LANES  per-lane valid; must be contiguous from lane 0.
- in_pc  in  LANES*XLEN  lane PCs.
- in_rd / in_rd_we  in  LANES*5 / LANES  destination register and write enable.
- in_value  in  LANES*XLEN  writeback data.
- in_exc / in_exc_code  in  LANES / LANES*CODE_W  synchronous exception (ecall included) and its cause.
- in_mret  in  LANES  lane is mret.
- priv_mode  in  2  0=U, 3=M.
- mstatus_mie  in  1  global interrupt enable.
- mip, mie  in  XLEN  pending and enable bits.
- mtvec, mepc  in  XLEN  trap vector and return PC.
- rf_we / rf_addr / rf_data  out  LANES / LANES*5 / LANES*XLEN  registered register-file write and forwarding port.
- csr_trap_valid  out  1  one-cycle trap pulse.
- csr_trap_is_int  out  1  trap is an interrupt.
- csr_trap_code  out  CODE_W  trap cause.
- csr_trap_pc  out  XLEN  epc.
- csr_mret  out  1  one-cycle mret pulse.
- redirect_valid / redirect_pc  out  1 / XLEN  front-end redirect.
- redirect_ack  in  1  front end has taken the redirect.
- retire_count  out  64  count of committed instructions.

## Operation
- FSM states: RUN and REDIRECT.
- in_ready = (state==RUN). A bundle is accepted on an edge where in_valid && in_ready.
- Interrupt check:
  - Interrupts are enabled when priv_mode==U, or when priv_mode==M && mstatus_mie.
  - pend = mip & mie.
  - Fixed priority among pending bits: 11, then 3, then 7.
  - An enabled interrupt attaches to lane 0 of the accepted bundle. Lane 0 and every younger lane are squashed. epc = in_pc[0].
- Otherwise, find the first lane i with in_exc:
  - Lanes before i commit; lane i and younger lanes are squashed.
  - Trap code = in_exc_code[i]; epc = in_pc[i].
- Otherwise, find the first lane j with in_mret:
  - Lanes up to and including j commit; younger lanes are squashed.
  - csr_mret pulses; redirect_pc = mepc.
- Trap target:
  - mtvec[1:0]==0 (direct): target = {mtvec[XLEN-1:2],2'b00}.
  - mtvec[1:0]==1 (vectored): interrupts go to base + 4*code; exceptions go to base.
  - mtvec[1:0] values 2 and 3 behave as direct.
- Any trap or mret moves the FSM to REDIRECT. redirect_valid is held, with redirect_pc stable, until redirect_ack is sampled high; the FSM then returns to RUN.
- Committed lane k drives rf_we[k]=in_rd_we[k] && (in_rd[k]!=0).
- retire_count += number of committed lanes, with 0..LANES committed per bundle. The trapping lane is not counted; an mret lane is counted. The counter wraps modulo 2^64.

## Timing
- Reset value of every output is 0, the state is RUN, and retire_count is 0. Because in_ready = (state==RUN), in_ready reads 1 out of reset.
- Latency is 1:
  - A bundle accepted at edge k produces rf_*, csr_trap_*, csr_mret and retire_count updates visible after edge k.
  - rf_we and the pulses last exactly one cycle.
- redirect_valid rises at edge k.
  - If redirect_ack is already high in that same cycle, the FSM is back in RUN after edge k+1.
  - In RUN, redirect_ack is ignored.
- in_valid with all in_lane_valid low is accepted as a no-op bundle: no commit, no trap, no count.
- Interrupt and exception in the same bundle: the interrupt wins.
- Exception and mret in the same bundle: the older lane wins.
- rst asserted mid-REDIRECT drops the redirect immediately, because reset is asynchronous.

## Configuration
- WB_DIFFTEST_EN defined:
  - Adds outputs dt_valid (LANES), dt_pc (LANES*XLEN) and dt_skip (LANES).
  - These are registered with the same timing as rf_we and mark each committed lane for the difftest commit trace.
- WB_DIFFTEST_EN undefined: the dt_* ports and their registers do not exist.

## Structure
- Package wb_pkg holds:
  - the state enum {RUN, REDIRECT};
  - the mode constants USER=0 and MACHINE=3;
  - the interrupt code constants 3, 7 and 11;
  - the per-lane input struct.
- Sub-module wb_trap_select is purely combinational. It performs the lane scan and interrupt priority and outputs commit_mask, trap_valid, is_int, code, epc and mret_hit. The top level holds the FSM, the output registers and the counter.

## Test plan
- LANES=2, both lanes valid, rd=5 and rd=6, no traps → after 1 cycle rf_we=2'b11, retire_count=2, redirect_valid=0.
- Lane 1 with in_exc, code 2 → lane 0 commits; csr_trap_valid pulse with code=2 and epc=in_pc[1]; redirect_pc=mtvec base; retire_count +1.
- M mode, mstatus_mie=1, mip=mie=1<<7, mtvec=0x8000_0001 → trap is_int=1, code 7, redirect_pc=0x8000_001C, rf_we=0.
- Lane 0 mret with mepc=0x1000 → csr_mret pulse, redirect_pc=0x1000; in_ready stays 0 until redirect_ack; in_ready is 1 the cycle after ack.
- Write to rd=0 → rf_we=0 but retire_count increments.
- Assert rst while in REDIRECT → redirect_valid=0 immediately and in_ready=1 after rst deasserts.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback/commit stage.
// Lane struct fields are sized for the widest supported XLEN (64).
package wb_pkg;

  typedef enum logic {
    RUN,
    REDIRECT
  } state_t;

  localparam logic [1:0] USER    = 2'd0;
  localparam logic [1:0] MACHINE = 2'd3;

  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;

  localparam int LANE_XLEN   = 64;
  localparam int LANE_CODE_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [LANE_XLEN-1:0]   pc;
    logic [4:0]             rd;
    logic                   rd_we;
    logic [LANE_XLEN-1:0]   value;
    logic                   exc;
    logic [LANE_CODE_W-1:0] exc_code;
    logic                   mret;
  } lane_t;

endpackage

// File: rtl/wb_trap_select.sv
// Combinational lane scan: oldest exception/mret, interrupt priority,
// commit mask and trap cause/epc for one bundle.
module wb_trap_select
  import wb_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int XLEN   = 64,
  parameter int CODE_W = 4
) (
  input  lane_t [LANES-1:0]  lanes_i,
  input  logic  [1:0]        priv_i,
  input  logic               mstatus_mie_i,
  input  logic  [XLEN-1:0]   mip_i,
  input  logic  [XLEN-1:0]   mie_i,
  output logic  [LANES-1:0]  commit_mask_o,
  output logic               trap_valid_o,
  output logic               is_int_o,
  output logic  [CODE_W-1:0] code_o,
  output logic  [XLEN-1:0]   epc_o,
  output logic               mret_hit_o
);

  logic [XLEN-1:0] pend;
  logic            int_en;
  logic            stop;
  logic            unused_lane_bits;

  assign pend   = mip_i & mie_i;
  assign int_en = (priv_i == USER) ||
                  ((priv_i == MACHINE) && mstatus_mie_i);

  always_comb begin
    commit_mask_o = '0;
    trap_valid_o  = 1'b0;
    is_int_o      = 1'b0;
    code_o        = '0;
    epc_o         = '0;
    mret_hit_o    = 1'b0;
    stop          = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (!stop) begin
        if (!lanes_i[k].valid) begin
          stop = 1'b1;
        end else if (lanes_i[k].exc) begin
          trap_valid_o = 1'b1;
          code_o       = CODE_W'(lanes_i[k].exc_code);
          epc_o        = XLEN'(lanes_i[k].pc);
          stop         = 1'b1;
        end else begin
          commit_mask_o[k] = 1'b1;
          if (lanes_i[k].mret) begin
            mret_hit_o = 1'b1;
            stop       = 1'b1;
          end
        end
      end
    end
    // an interrupt takes lane 0 and overrides everything younger
    if (int_en && lanes_i[0].valid &&
        (pend[IRQ_MEI] || pend[IRQ_MSI] || pend[IRQ_MTI])) begin
      commit_mask_o = '0;
      mret_hit_o    = 1'b0;
      trap_valid_o  = 1'b1;
      is_int_o      = 1'b1;
      epc_o         = XLEN'(lanes_i[0].pc);
      if (pend[IRQ_MEI])
        code_o = CODE_W'(IRQ_MEI);
      else if (pend[IRQ_MSI])
        code_o = CODE_W'(IRQ_MSI);
      else
        code_o = CODE_W'(IRQ_MTI);
    end
  end

  always_comb begin
    unused_lane_bits = 1'b0;
    for (int k = 0; k < LANES; k++)
      unused_lane_bits = unused_lane_bits ^
        (^{lanes_i[k].rd, lanes_i[k].rd_we,
           lanes_i[k].value, lanes_i[k].pc});
    unused_lane_bits = unused_lane_bits ^ (^{mip_i, mie_i});
  end

endmodule

// File: rtl/writeback_commit_n.sv
// N-lane writeback/commit stage with trap/mret redirect FSM.
// Optional difftest trace ports under WB_DIFFTEST_EN.
module writeback_commit_n
  import wb_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int XLEN   = 64,
  parameter int CODE_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_valid,
  input  logic [LANES*XLEN-1:0]   in_pc,
  input  logic [LANES*5-1:0]      in_rd,
  input  logic [LANES-1:0]        in_rd_we,
  input  logic [LANES*XLEN-1:0]   in_value,
  input  logic [LANES-1:0]        in_exc,
  input  logic [LANES*CODE_W-1:0] in_exc_code,
  input  logic [LANES-1:0]        in_mret,
  input  logic [1:0]              priv_mode,
  input  logic                    mstatus_mie,
  input  logic [XLEN-1:0]         mip,
  input  logic [XLEN-1:0]         mie,
  input  logic [XLEN-1:0]         mtvec,
  input  logic [XLEN-1:0]         mepc,
  output logic [LANES-1:0]        rf_we,
  output logic [LANES*5-1:0]      rf_addr,
  output logic [LANES*XLEN-1:0]   rf_data,
  output logic                    csr_trap_valid,
  output logic                    csr_trap_is_int,
  output logic [CODE_W-1:0]       csr_trap_code,
  output logic [XLEN-1:0]         csr_trap_pc,
  output logic                    csr_mret,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc,
  input  logic                    redirect_ack,
  output logic [63:0]             retire_count
`ifdef WB_DIFFTEST_EN
  ,
  output logic [LANES-1:0]        dt_valid,
  output logic [LANES*XLEN-1:0]   dt_pc,
  output logic [LANES-1:0]        dt_skip
`endif
);

  state_t              state_q;
  lane_t [LANES-1:0]   lanes;
  logic  [LANES-1:0]   commit;
  logic                trap_valid;
  logic                is_int;
  logic  [CODE_W-1:0]  code;
  logic  [XLEN-1:0]    epc;
  logic                mret_hit;
  logic                accept;
  logic  [LANES-1:0]   rf_we_d;
  logic  [63:0]        cnt_d;
  logic  [XLEN-1:0]    base;
  logic  [XLEN-1:0]    target_d;

  logic [LANES-1:0]      rf_we_q;
  logic [LANES*5-1:0]    rf_addr_q;
  logic [LANES*XLEN-1:0] rf_data_q;
  logic                  trap_valid_q;
  logic                  is_int_q;
  logic [CODE_W-1:0]     code_q;
  logic [XLEN-1:0]       epc_q;
  logic                  mret_q;
  logic                  rv_q;
  logic [XLEN-1:0]       rpc_q;
  logic [63:0]           retire_q;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lanes[k].valid    = in_lane_valid[k];
      lanes[k].pc       = LANE_XLEN'(in_pc[k*XLEN +: XLEN]);
      lanes[k].rd       = in_rd[k*5 +: 5];
      lanes[k].rd_we    = in_rd_we[k];
      lanes[k].value    = LANE_XLEN'(in_value[k*XLEN +: XLEN]);
      lanes[k].exc      = in_exc[k];
      lanes[k].exc_code = LANE_CODE_W'(in_exc_code[k*CODE_W +: CODE_W]);
      lanes[k].mret     = in_mret[k];
    end
  end

  wb_trap_select #(
    .LANES (LANES),
    .XLEN  (XLEN),
    .CODE_W(CODE_W)
  ) u_sel (
    .lanes_i      (lanes),
    .priv_i       (priv_mode),
    .mstatus_mie_i(mstatus_mie),
    .mip_i        (mip),
    .mie_i        (mie),
    .commit_mask_o(commit),
    .trap_valid_o (trap_valid),
    .is_int_o     (is_int),
    .code_o       (code),
    .epc_o        (epc),
    .mret_hit_o   (mret_hit)
  );

  assign in_ready = (state_q == RUN);
  assign accept   = in_valid && in_ready;
  assign base     = {mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    cnt_d = '0;
    for (int k = 0; k < LANES; k++) begin
      rf_we_d[k] = commit[k] && in_rd_we[k] && (in_rd[k*5 +: 5] != 5'd0);
      cnt_d      = cnt_d + 64'(commit[k]);
    end
    if (mret_hit)
      target_d = mepc;
    else if (is_int && (mtvec[1:0] == 2'b01))
      target_d = base + (XLEN'(code) << 2);
    else
      target_d = base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      rf_we_q      <= '0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      trap_valid_q <= 1'b0;
      is_int_q     <= 1'b0;
      code_q       <= '0;
      epc_q        <= '0;
      mret_q       <= 1'b0;
      rv_q         <= 1'b0;
      rpc_q        <= '0;
      retire_q     <= '0;
    end else begin
      rf_we_q      <= '0;
      trap_valid_q <= 1'b0;
      mret_q       <= 1'b0;
      if (accept) begin
        rf_we_q      <= rf_we_d;
        rf_addr_q    <= in_rd;
        rf_data_q    <= in_value;
        trap_valid_q <= trap_valid;
        is_int_q     <= is_int;
        code_q       <= code;
        epc_q        <= epc;
        mret_q       <= mret_hit;
        retire_q     <= retire_q + cnt_d;
      end
      unique case (state_q)
        RUN: begin
          if (accept && (trap_valid || mret_hit)) begin
            state_q <= REDIRECT;
            rv_q    <= 1'b1;
            rpc_q   <= target_d;
          end
        end
        REDIRECT: begin
          if (redirect_ack) begin
            state_q <= RUN;
            rv_q    <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign rf_we           = rf_we_q;
  assign rf_addr         = rf_addr_q;
  assign rf_data         = rf_data_q;
  assign csr_trap_valid  = trap_valid_q;
  assign csr_trap_is_int = is_int_q;
  assign csr_trap_code   = code_q;
  assign csr_trap_pc     = epc_q;
  assign csr_mret        = mret_q;
  assign redirect_valid  = rv_q;
  assign redirect_pc     = rpc_q;
  assign retire_count    = retire_q;

`ifdef WB_DIFFTEST_EN
  logic [LANES-1:0]      dt_valid_q;
  logic [LANES*XLEN-1:0] dt_pc_q;
  logic [LANES-1:0]      dt_skip_q;

  // mret lanes are flagged so the reference model resyncs CSR state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dt_valid_q <= '0;
      dt_pc_q    <= '0;
      dt_skip_q  <= '0;
    end else begin
      dt_valid_q <= '0;
      dt_skip_q  <= '0;
      if (accept) begin
        dt_valid_q <= commit;
        dt_pc_q    <= in_pc;
        dt_skip_q  <= commit & in_mret;
      end
    end
  end

  assign dt_valid = dt_valid_q;
  assign dt_pc    = dt_pc_q;
  assign dt_skip  = dt_skip_q;
`endif

endmodule
